// File: rtl/pool_ctrl_if.sv
// Source-buffer read port and pool-datapath handshake bundle for pool_ctrl.
// The controller uses the master modport. The buffer/datapath side uses slave.
interface pool_ctrl_if #(
  parameter int MAT_MUL_SIZE  = 4,
  parameter int DWIDTH        = 8,
  parameter int AWIDTH        = 10,
  parameter int MAX_BITS_POOL = 3
);
  logic                           src_rd_en;
  logic [AWIDTH-1:0]              src_rd_addr;
  logic [MAT_MUL_SIZE*DWIDTH-1:0] src_rd_data;
  logic                           dst_ready;
  logic                           pool_enable;
  logic [MAX_BITS_POOL-1:0]       pool_window_size;
  logic                           pool_in_data_available;
  logic [MAT_MUL_SIZE*DWIDTH-1:0] pool_inp_data;
  logic                           pool_out_data_available;

  modport master (
    output src_rd_en, src_rd_addr, pool_enable, pool_window_size,
           pool_in_data_available, pool_inp_data,
    input  src_rd_data, dst_ready, pool_out_data_available
  );

  modport slave (
    input  src_rd_en, src_rd_addr, pool_enable, pool_window_size,
           pool_in_data_available, pool_inp_data,
    output src_rd_data, dst_ready, pool_out_data_available
  );
endinterface

// File: rtl/pool_ctrl.sv
// Sequences one pooling pass: streams rows from the source buffer into the pool
// datapath, counts completed outputs, and pulses done (or err_cfg on a bad window).
//
// state  | meaning
// IDLE   | waiting for start; outputs quiet
// STREAM | issuing source reads while dst_ready allows
// DRAIN  | all reads issued, waiting for datapath outputs
// FIN    | one-cycle done pulse, then back to IDLE
module pool_ctrl #(
  parameter int MAT_MUL_SIZE  = 4,
  parameter int DWIDTH        = 8,
  parameter int AWIDTH        = 10,
  parameter int MAX_BITS_POOL = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     cfg_enable_pool,
  input  logic [MAX_BITS_POOL-1:0] cfg_window_size,
  input  logic [AWIDTH-1:0]        cfg_base_addr,
  input  logic [AWIDTH-1:0]        cfg_num_rows,
  pool_ctrl_if.master              bus,
  output logic                     busy,
  output logic                     done,
  output logic                     err_cfg
);

  localparam int ROW_W = MAT_MUL_SIZE * DWIDTH;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FIN    = 2'd3;

  logic [1:0]               state;
  logic [AWIDTH:0]          issued;
  logic [AWIDTH:0]          complete;
  logic [AWIDTH:0]          num_rows;
  logic [AWIDTH-1:0]        base_addr;
  logic                     enable_pool;
  logic [MAX_BITS_POOL-1:0] window_size;
  logic                     rd_en_q;
  logic                     err_q;

  logic                     active;
  logic                     win_legal;
  logic                     issue;
  logic                     out_hit;
  logic [AWIDTH:0]          complete_next;
  logic [ROW_W-1:0]         row;

  assign active    = (state != S_IDLE);
  assign win_legal = (cfg_window_size == MAX_BITS_POOL'(1)) ||
                     (cfg_window_size == MAX_BITS_POOL'(2)) ||
                     (cfg_window_size == MAX_BITS_POOL'(4));
  assign issue     = (state == S_STREAM) && bus.dst_ready && (issued < num_rows) && !reset;
  assign out_hit   = active && bus.pool_out_data_available;
  // Include this cycle's output so DRAIN leaves on the same edge the last row lands.
  assign complete_next = complete + {{AWIDTH{1'b0}}, out_hit};

  assign row                        = bus.src_rd_data;
  assign bus.pool_inp_data          = row;
  assign bus.src_rd_en              = issue;
  assign bus.src_rd_addr            = (active && !reset) ? base_addr + issued[AWIDTH-1:0] : '0;
  assign bus.pool_in_data_available = rd_en_q && !reset;
  assign bus.pool_enable            = active && !reset && enable_pool;
  assign bus.pool_window_size       = (active && !reset) ? window_size : '0;

  assign busy    = active && !reset;
  assign done    = (state == S_FIN) && !reset;
  assign err_cfg = err_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      issued      <= '0;
      complete    <= '0;
      num_rows    <= '0;
      base_addr   <= '0;
      enable_pool <= 1'b0;
      window_size <= '0;
      rd_en_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rd_en_q <= issue;
      err_q   <= 1'b0;
      if (active) complete <= complete_next;

      case (state)
        S_IDLE: begin
          if (start) begin
            enable_pool <= cfg_enable_pool;
            window_size <= cfg_window_size;
            base_addr   <= cfg_base_addr;
            num_rows    <= {1'b0, cfg_num_rows};
            issued      <= '0;
            complete    <= '0;
            if (!win_legal)                state <= S_IDLE;
            else if (cfg_num_rows == '0)   state <= S_FIN;
            else                           state <= S_STREAM;
            err_q <= !win_legal;
          end
        end
        S_STREAM: begin
          if (issue) begin
            issued <= issued + 1'b1;
            if (issued + 1'b1 == num_rows) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (complete_next >= num_rows) state <= S_FIN;
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pool_ctrl.md
POOL_CTRL -- requirements
Module: pool_ctrl

Interface
REQ-001 SHALL have parameter MAT_MUL_SIZE, default 4, meaning lanes per row.
REQ-002 SHALL have parameter DWIDTH, default 8, meaning bits per lane.
REQ-003 SHALL have parameter AWIDTH, default 10, meaning source address and row-count width.
REQ-004 SHALL have parameter MAX_BITS_POOL, default 3, meaning pool window field width.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on posedge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port start, input, 1 bit: pass request, sampled only in IDLE.
REQ-008 SHALL have port cfg_enable_pool, input, 1 bit: pooling on (1) or bypass (0).
REQ-009 SHALL have port cfg_window_size, input, MAX_BITS_POOL bits: window size; legal values 1, 2, 4.
REQ-010 SHALL have port cfg_base_addr, input, AWIDTH bits: first source row address.
REQ-011 SHALL have port cfg_num_rows, input, AWIDTH bits: rows in the pass; 0 means no-op.
REQ-012 SHALL have port src_rd_en, output, 1 bit: source buffer read strobe.
REQ-013 SHALL have port src_rd_addr, output, AWIDTH bits: source read address.
REQ-014 SHALL have port src_rd_data, input, MAT_MUL_SIZE*DWIDTH bits: read data, valid the cycle after src_rd_en.
REQ-015 SHALL have port dst_ready, input, 1 bit: downstream can accept; low stalls read issue.
REQ-016 SHALL have port pool_enable, output, 1 bit: drives the pool datapath enable.
REQ-017 SHALL have port pool_window_size, output, MAX_BITS_POOL bits: drives the pool window size.
REQ-018 SHALL have port pool_in_data_available, output, 1 bit: datapath input valid.
REQ-019 SHALL have port pool_inp_data, output, MAT_MUL_SIZE*DWIDTH bits: datapath input row.
REQ-020 SHALL have port pool_out_data_available, input, 1 bit: datapath output valid.
REQ-021 SHALL have port busy, output, 1 bit: pass in progress.
REQ-022 SHALL have port done, output, 1 bit: one-cycle pulse on pass completion.
REQ-023 SHALL have port err_cfg, output, 1 bit: one-cycle pulse on an illegal window size.

Function
REQ-024 SHALL implement FSM states IDLE, STREAM, DRAIN, FIN.
REQ-025 In IDLE with start=1, SHALL latch all cfg_* inputs into internal registers and use only the latched copies until the pass ends.
REQ-026 On an illegal window size at start (not 1, 2 or 4), SHALL pulse err_cfg next cycle, stay in IDLE, and issue no reads.
REQ-027 On a legal start with cfg_num_rows=0, SHALL go to FIN and pulse done next cycle with no reads.
REQ-028 On a legal start with cfg_num_rows>0, SHALL go to STREAM and clear the issue and complete counters.
REQ-029 In STREAM, each cycle with dst_ready=1 and issued<num_rows, SHALL assert src_rd_en with src_rd_addr = base+issued (mod 2^AWIDTH) and increment issued.
REQ-030 In STREAM with dst_ready=0, SHALL hold src_rd_en=0 and hold the address and counters.
REQ-031 When issued reaches num_rows, SHALL move to DRAIN.
REQ-032 pool_in_data_available SHALL equal src_rd_en delayed one cycle (registered); pool_inp_data SHALL be src_rd_data passed through combinationally.
REQ-033 pool_enable and pool_window_size SHALL drive the latched config while busy, and 0 in IDLE.
REQ-034 SHALL increment the complete counter on every cycle pool_out_data_available=1 while busy.
REQ-035 In DRAIN, when complete reaches num_rows, SHALL move to FIN.
REQ-036 In FIN, SHALL assert done for exactly one cycle and then return to IDLE.
REQ-037 busy SHALL be 1 in STREAM, DRAIN and FIN, and 0 in IDLE.
REQ-038 start while busy SHALL be ignored, with no effect on config or counters.
REQ-039 Counters SHALL be AWIDTH+1 bits so that num_rows = 2^AWIDTH-1 never overflows.
REQ-040 Without stalls and with pooling enabled (one-cycle datapath), start sampled at edge T0 SHALL give first src_rd_en in cycle T1 and done in cycle T(N+3).

Reset
REQ-041 With reset=1 at a clock edge, SHALL enter IDLE and clear counters and latched config.
REQ-042 During reset, SHALL drive src_rd_en, pool_in_data_available, pool_enable, busy, done and err_cfg to 0, and src_rd_addr and pool_window_size to 0.
REQ-043 reset mid-pass SHALL abort the pass with no done pulse; the next start SHALL begin a fresh pass.

Verification
REQ-044 Bench SHALL cover: window=2, base=0x10, N=4, dst_ready=1 -> reads at 0x10..0x13 in cycles T1..T4; done only in T7; busy high T1..T7.
REQ-045 Bench SHALL cover: window=3 -> err_cfg pulse in T1; src_rd_en never asserts; busy stays 0.
REQ-046 Bench SHALL cover: N=0 -> done in T1; zero reads.
REQ-047 Bench SHALL cover: N=4, dst_ready low for 2 cycles after the second read -> exactly 4 reads with addresses contiguous; done delayed 2 cycles to T9.
REQ-048 Bench SHALL cover: base=0x3FE, N=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-049 Bench SHALL cover: reset after 2 reads of N=8, then a new start with N=2 -> no done for the aborted pass; exactly 2 reads; one done.
